// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and the 3x-oversampling receiver:
// frame state encoding, data width, and the baud divider / phase geometry.
package uart_pkg;

    // Data bits per frame; the link is always 8-bit.
    localparam int DW      = 8;

    // Divider width: bit period = PHASE_N * (SmplCLKP + 1) clk cycles.
    localparam int DIV_W   = 7;

    // Phases per bit. This matches the receiver's 3x oversampling.
    localparam int PHASE_N = 3;
    localparam int PHASE_W = 2;

    // Frame states, common to both ends of the link.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Parity bit that makes the receiver's check pass.
    // Odd parity gives an odd total count of ones over data plus parity.
    function automatic logic parity_bit(input logic [DW-1:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud tick generator: a divider running 0..SmplCLKP and a phase counter
// running 0..PHASE_N-1. tick marks the last clk of each bit period.
// clr holds both counters at zero, so the bit that follows clr has a full length.
// The receiver's sampler reuses this block.
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] SmplCLKP,
    output logic             tick
);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASE_N - 1);

    logic [DIV_W-1:0]   cnt;
    logic [PHASE_W-1:0] phase;
    logic               cnt_wrap;

    // The divider compares for equality and never runs past SmplCLKP.
    // This keeps SmplCLKP=127 inside 7 bits.
    assign cnt_wrap = (cnt == SmplCLKP);
    assign tick     = cnt_wrap && (phase == PHASE_LAST);

    // Divider and phase counters. The phase counter advances each time the divider wraps.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments. Every register then
        // updates from the values present before the edge, whatever the statement order.
        if (rst || clr) begin
            cnt   <= '0;
            phase <= '0;
        end else if (cnt_wrap) begin
            cnt   <= '0;
            phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts one byte per din_vld/tx_rdy handshake and sends
// start bit, 8 data bits LSB first, an optional parity bit and the stop bit(s).
// The divider and parity controls are encoded as in the 3x-oversampling receiver.
// Configuration macro: UART_TX_TWO_STOP_EN. When it is defined, the stop state
// lasts two bit periods. When it is undefined, there is one stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DW = uart_pkg::DW
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             sel_check,
    input  logic             parity_check,
    input  logic [DIV_W-1:0] SmplCLKP,
    input  logic [DW-1:0]    din,
    input  logic             din_vld,
    output logic             tx_rdy,
    output logic             tx_done,
    output logic             Tx
);

    uart_state_e      state;
    logic [DW-1:0]    data_q;
    logic             par_en_q;
    logic             par_odd_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       bit_idx;
    logic             tick;
    logic             accept;
    logic             baud_clr;
`ifdef UART_TX_TWO_STOP_EN
    logic             stop_second;
`endif

    // tx_rdy is registered and is high only in IDLE, so this is the handshake.
    assign accept   = din_vld && tx_rdy;

    // The divider is held cleared in IDLE. Counting therefore starts from zero
    // at the accept edge, and the start bit has a full period.
    assign baud_clr = (state == IDLE);

    uart_baud_tick u_baud_tick (
        .clk      (clk),
        .rst      (rst),
        .clr      (baud_clr),
        .SmplCLKP (div_q),
        .tick     (tick)
    );

    // Frame FSM. Tx, tx_rdy and tx_done are all registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            Tx        <= 1'b1;
            tx_rdy    <= 1'b1;
            tx_done   <= 1'b0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            div_q     <= '0;
            bit_idx   <= '0;
`ifdef UART_TX_TWO_STOP_EN
            stop_second <= 1'b0;
`endif
        end else begin
            // tx_done defaults low. The stop tick below is the only place that sets it,
            // so it lasts exactly one clk.
            tx_done <= 1'b0;

            case (state)
                IDLE: begin
                    Tx <= 1'b1;
                    if (accept) begin
                        // The frame configuration is captured here. Later changes on the
                        // inputs do not affect the frame in progress.
                        data_q    <= din;
                        par_en_q  <= sel_check;
                        par_odd_q <= parity_check;
                        div_q     <= SmplCLKP;
                        bit_idx   <= '0;
                        Tx        <= 1'b0;
                        tx_rdy    <= 1'b0;
                        state     <= START;
                    end
                end

                START: begin
                    if (tick) begin
                        Tx    <= data_q[0];
                        state <= DATA;
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
                            if (par_en_q) begin
                                Tx    <= parity_bit(data_q, par_odd_q);
                                state <= PARITY;
                            end else begin
                                Tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            Tx      <= data_q[bit_idx + 3'd1];
                        end
                    end
                end

                PARITY: begin
                    if (tick) begin
                        Tx    <= 1'b1;
                        state <= STOP;
                    end
                end

                STOP: begin
                    if (tick) begin
`ifdef UART_TX_TWO_STOP_EN
                        if (!stop_second) begin
                            stop_second <= 1'b1;
                        end else begin
                            stop_second <= 1'b0;
                            tx_done     <= 1'b1;
                            tx_rdy      <= 1'b1;
                            state       <= IDLE;
                        end
`else
                        tx_done <= 1'b1;
                        tx_rdy  <= 1'b1;
                        state   <= IDLE;
`endif
                    end
                end

                default: begin
                    Tx     <= 1'b1;
                    tx_rdy <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. The stimulus pushes one expected-frame
// record per accepted byte. A monitor watches Tx and rebuilds each frame from
// the framing rules (start, LSB-first data, parity by count of ones, stop),
// then compares timing and levels against the DUT's output.
`timescale 1ns/1ps
module tb_uart_tx;

`ifdef UART_TX_TWO_STOP_EN
    localparam bit TWO_STOP = 1'b1;
`else
    localparam bit TWO_STOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       sel_check;
    logic       parity_check;
    logic [6:0] SmplCLKP;
    logic [7:0] din;
    logic       din_vld;
    logic       tx_rdy;
    logic       tx_done;
    logic       Tx;

    always #5 clk = ~clk;

    uart_tx dut (
        .clk          (clk),
        .rst          (rst),
        .sel_check    (sel_check),
        .parity_check (parity_check),
        .SmplCLKP     (SmplCLKP),
        .din          (din),
        .din_vld      (din_vld),
        .tx_rdy       (tx_rdy),
        .tx_done      (tx_done),
        .Tx           (Tx)
    );

    typedef struct {
        logic [7:0] data;
        bit         par_en;
        bit         par_odd;
        int         div;
        bit         b2b;       // expect the start bit right after the tx_done clk
        int         abort_at;  // sample index where reset shows, -1 if none
        int         id;
    } exp_t;

    typedef bit bitq_t[$];

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   frame_id = 0;
    bit   mon_start = 1'b0;
    bit   mon_busy  = 1'b0;

    task automatic check(input string name, input int id,
                         input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s frame=%0d got=%0h want=%0h", name, id, actual, expected);
        end
    endtask

    // Reference model: the line levels of one frame, one entry per bit period.
    function automatic bitq_t frame_bits(input exp_t e);
        bitq_t q;
        int    ones;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(e.data[i]);
        if (e.par_en) begin
            ones = $countones(e.data);
            // odd parity: data+parity has an odd number of ones
            q.push_back(((ones % 2) == 0) ? e.par_odd : !e.par_odd);
        end
        q.push_back(1'b1);
        if (TWO_STOP) q.push_back(1'b1);
        return q;
    endfunction

    // Check one frame. The current negedge is sample 0, the first clk of the start bit.
    task automatic run_frame(input int idle_before);
        exp_t  e;
        bitq_t bits;
        int    tb, len, match, rdy_hi, done_hi;
        bit    aborted;
        e       = exp_q.pop_front();
        bits    = frame_bits(e);
        tb      = 3 * (e.div + 1);
        len     = bits.size() * tb;
        match   = 0;
        rdy_hi  = 0;
        done_hi = 0;
        aborted = 1'b0;
        if (e.b2b) check("b2b_gap", e.id, idle_before, 0);
        for (int s = 0; s < len; s++) begin
            if (s > 0) @(negedge clk);
            if (e.abort_at == s) begin
                check("abort_tx", e.id, Tx, 1);
                check("abort_rdy", e.id, tx_rdy, 1);
                check("abort_done", e.id, tx_done, 0);
                aborted = 1'b1;
                break;
            end
            if (Tx === bits[s / tb]) match++;
            if (tx_rdy !== 1'b0) rdy_hi++;
            if (tx_done !== 1'b0) done_hi++;
            if ((s % tb) == tb - 1) begin
                check($sformatf("bit%0d_clks", s / tb), e.id, match, tb);
                match = 0;
            end
        end
        check("rdy_low_in_frame", e.id, rdy_hi, 0);
        check("done_early", e.id, done_hi, 0);
        if (!aborted) begin
            @(negedge clk);
            check("done_pulse", e.id, tx_done, 1);
            check("end_tx_high", e.id, Tx, 1);
            check("end_rdy", e.id, tx_rdy, 1);
        end
    endtask

    // Monitor: idle samples must be quiet; a falling Tx starts a frame check.
    initial begin
        int idle_cnt;
        int skip;
        wait (mon_start);
        idle_cnt = 0;
        forever begin
            @(negedge clk);
            if (Tx !== 1'b0) begin
                check("idle_done", -1, tx_done, 0);
                idle_cnt++;
            end else begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", -1, exp_q.size(), 1);
                    skip = 0;
                    while (Tx === 1'b0 && skip < 5000) begin
                        @(negedge clk);
                        skip++;
                    end
                end else begin
                    run_frame(idle_cnt);
                end
                idle_cnt = 0;
                mon_busy = 1'b0;
            end
        end
    end

    // Wait for tx_rdy, present a byte, and push its expected frame.
    // abort_at >= 0 pulses rst so that reset shows at that frame sample.
    task automatic send(input logic [7:0] d, input bit pe, input bit po,
                        input logic [6:0] div, input bit hold, input bit b2b,
                        input int abort_at);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (tx_rdy !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("rdy_before_send", frame_id, tx_rdy, 1);
        din          = d;
        sel_check    = pe;
        parity_check = po;
        SmplCLKP     = div;
        din_vld      = 1'b1;
        e.data     = d;
        e.par_en   = pe;
        e.par_odd  = po;
        e.div      = int'(div);
        e.b2b      = b2b;
        e.abort_at = abort_at;
        e.id       = frame_id;
        exp_q.push_back(e);
        frame_id++;
        @(posedge clk);
        #1;
        if (!hold) begin
            din_vld = 1'b0;
            din     = 8'($urandom_range(255, 0));
        end
        // Configuration changes during the frame must have no effect.
        sel_check    = 1'($urandom_range(1, 0));
        parity_check = 1'($urandom_range(1, 0));
        SmplCLKP     = 7'($urandom_range(127, 0));
        if (abort_at >= 0) begin
            @(negedge clk);
            repeat (abort_at - 1) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    initial begin
        int  n;
        bit  prev_hold;
        bit  hold;
        rst          = 1'b1;
        din          = 8'h00;
        din_vld      = 1'b0;
        sel_check    = 1'b0;
        parity_check = 1'b0;
        SmplCLKP     = 7'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", -1, Tx, 1);
        check("rst_rdy", -1, tx_rdy, 1);
        check("rst_done", -1, tx_done, 0);
        rst       = 1'b0;
        mon_start = 1'b1;

        // Basic frame, 9-clk bits, no parity.
        send(8'h55, 1'b0, 1'b0, 7'd2, 1'b0, 1'b0, -1);
        // Parity bit, odd then even.
        send(8'hA5, 1'b1, 1'b1, 7'd2, 1'b0, 1'b0, -1);
        send(8'hA5, 1'b1, 1'b0, 7'd2, 1'b0, 1'b0, -1);
        // din_vld held high across two frames.
        send(8'h00, 1'b0, 1'b0, 7'd2, 1'b1, 1'b0, -1);
        send(8'hFF, 1'b0, 1'b0, 7'd2, 1'b0, 1'b1, -1);
        // Reset in the middle of data bit 3, then a clean frame.
        send(8'hC3, 1'b0, 1'b0, 7'd2, 1'b0, 1'b0, 4 * 9 + 3);
        send(8'h96, 1'b1, 1'b1, 7'd2, 1'b0, 1'b0, -1);
        // Stop bit length (one or two stop bits, depending on the build).
        send(8'h3C, 1'b0, 1'b0, 7'd2, 1'b0, 1'b0, -1);
        // Divider extremes.
        send(8'($urandom_range(255, 0)), 1'b1, 1'b0, 7'd0,   1'b0, 1'b0, -1);
        send(8'($urandom_range(255, 0)), 1'b0, 1'b0, 7'd0,   1'b0, 1'b0, -1);
        send(8'($urandom_range(255, 0)), 1'b1, 1'b1, 7'd127, 1'b0, 1'b0, -1);
        send(8'($urandom_range(255, 0)), 1'b0, 1'b0, 7'd127, 1'b0, 1'b0, -1);
        send(8'($urandom_range(255, 0)), 1'b1, 1'b0, 7'd127, 1'b0, 1'b0, -1);

        // Random bytes, parity modes and short dividers, mixed with held valids.
        prev_hold = 1'b0;
        for (int i = 0; i < 150; i++) begin
            hold = (i < 149) ? 1'($urandom_range(1, 0)) : 1'b0;
            send(8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)),
                 1'($urandom_range(1, 0)), 7'($urandom_range(3, 0)),
                 hold, prev_hold, -1);
            prev_hold = hold;
        end

        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check("drain", -1, exp_q.size(), 0);
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hang guard.
    initial begin
        #(10 * 90000);
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
